// File: rtl/banked_bram_pkg.sv
// Shared types and constants for the banked BRAM loader: loader FSM states and fill-order encodings.
package banked_bram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

    localparam int LOAD_ORDER_ADDR_MAJOR = 0;
    localparam int LOAD_ORDER_BANK_MAJOR = 1;

endpackage

// File: rtl/banked_bram_loader_if.sv
// Streaming-load and parallel-read bus of the banked BRAM loader.
interface banked_bram_loader_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int BANK_CNT        = 8,
    parameter int BANK_ADDR_WIDTH = 3
);
    logic                                 load_start;
    logic                                 in_valid;
    logic                                 in_ready;
    logic [DATA_WIDTH-1:0]                din;
    logic                                 load_done;
    logic                                 rd_en;
    logic [BANK_ADDR_WIDTH-1:0]           rd_addr;
    logic                                 rd_valid;
    logic [BANK_CNT-1:0][DATA_WIDTH-1:0]  dout;

    modport master (
        output load_start, in_valid, din, rd_en, rd_addr,
        input  in_ready, load_done, rd_valid, dout
    );

    modport slave (
        input  load_start, in_valid, din, rd_en, rd_addr,
        output in_ready, load_done, rd_valid, dout
    );

endinterface

// File: rtl/banked_bram_loader_bank_ram.sv
// One bank: simple dual-port RAM, one write port and one registered read port.
module bank_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // NOTE: the array has no reset branch so it maps onto block RAM; only the output register resets.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/banked_bram_loader.sv
// Banked BRAM with a self-sequencing streaming loader and a parallel (all-bank) read pipeline
// of one or two cycles latency.
module banked_bram_loader
    import banked_bram_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int BANK_ID_WIDTH   = 3,
    parameter int BANK_CNT        = 2**BANK_ID_WIDTH,
    parameter int BANK_ADDR_WIDTH = 3,
    parameter int BANK_SIZE       = 2**BANK_ADDR_WIDTH,
    parameter int LOAD_ORDER      = LOAD_ORDER_ADDR_MAJOR,
    parameter int READ_LATENCY    = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    banked_bram_loader_if.slave   bus
);

    load_state_t                          state_q, state_d;
    logic [BANK_ID_WIDTH-1:0]             bank_cnt_q, bank_cnt_d;
    logic [BANK_ADDR_WIDTH-1:0]           addr_cnt_q, addr_cnt_d;
    logic                                 rd_v1_q, rd_v1_d;
    logic                                 xfer, bank_last, addr_last, rd_acc;
    logic [BANK_CNT-1:0][DATA_WIDTH-1:0]  ram_rdata;

    assign xfer      = (state_q == LOAD) && bus.in_valid;
    assign bank_last = (bank_cnt_q == BANK_ID_WIDTH'(BANK_CNT - 1));
    assign addr_last = (addr_cnt_q == BANK_ADDR_WIDTH'(BANK_SIZE - 1));
    assign rd_acc    = bus.rd_en && (state_q == DONE);

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.load_done = (state_q == DONE);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        bank_cnt_d = bank_cnt_q;
        addr_cnt_d = addr_cnt_q;
        rd_v1_d    = rd_acc;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.load_start) begin
                    state_d    = LOAD;
                    bank_cnt_d = '0;
                    addr_cnt_d = '0;
                end
            end
            LOAD: begin
                if (xfer) begin
                    if (bank_last && addr_last) begin
                        state_d    = DONE;
                        bank_cnt_d = '0;
                        addr_cnt_d = '0;
                    end else if (LOAD_ORDER == LOAD_ORDER_ADDR_MAJOR) begin
                        bank_cnt_d = bank_cnt_q + 1'b1;
                        if (bank_last) begin
                            addr_cnt_d = addr_cnt_q + 1'b1;
                        end
                    end else begin
                        addr_cnt_d = addr_cnt_q + 1'b1;
                        if (addr_last) begin
                            bank_cnt_d = bank_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bank_cnt_q <= '0;
            addr_cnt_q <= '0;
            rd_v1_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_cnt_q <= bank_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            rd_v1_q    <= rd_v1_d;
        end
    end

    for (genvar i = 0; i < BANK_CNT; i++) begin : g_bank
        localparam logic [BANK_ID_WIDTH-1:0] BANK_ID = BANK_ID_WIDTH'(i);

        bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (BANK_ADDR_WIDTH),
            .DEPTH      (BANK_SIZE)
        ) u_ram (
            .clock   (clock),
            .reset_n (reset_n),
            .we      (xfer && (bank_cnt_q == BANK_ID)),
            .waddr   (addr_cnt_q),
            .wdata   (bus.din),
            .re      (rd_acc),
            .raddr   (bus.rd_addr),
            .rdata   (ram_rdata[i])
        );
    end

    // The bank output registers already hold their last read, so stage 2 only loads on a valid stage 1.
    if (READ_LATENCY == 2) begin : g_lat2
        logic                                 rd_v2_q, rd_v2_d;
        logic [BANK_CNT-1:0][DATA_WIDTH-1:0]  dout_q, dout_d;

        always_comb begin
            rd_v2_d = rd_v1_q;
            dout_d  = dout_q;
            if (rd_v1_q) begin
                dout_d = ram_rdata;
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                rd_v2_q <= 1'b0;
                dout_q  <= '0;
            end else begin
                rd_v2_q <= rd_v2_d;
                dout_q  <= dout_d;
            end
        end

        assign bus.rd_valid = rd_v2_q;
        assign bus.dout     = dout_q;
    end else begin : g_lat1
        assign bus.rd_valid = rd_v1_q;
        assign bus.dout     = ram_rdata;
    end

endmodule

// File: tb/tb_banked_bram_loader.sv
// Bench for banked_bram_loader: an address-major/latency-1 and a bank-major/latency-2 instance
// share one random stimulus stream; a matrix model and per-instance scoreboards check reads.
module tb_banked_bram_loader;

    localparam int NW = 64;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       load_start, in_valid, rd_en;
    logic [7:0] din;
    logic [2:0] rd_addr;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   loading, loaded;
    int   words;
    logic [7:0] ref_mem [2][8][8];
    exp_t q [2][$];
    int   lat [2] = '{1, 2};

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    banked_bram_loader_if #(.DATA_WIDTH(8), .BANK_CNT(8), .BANK_ADDR_WIDTH(3)) bus_a ();
    banked_bram_loader_if #(.DATA_WIDTH(8), .BANK_CNT(8), .BANK_ADDR_WIDTH(3)) bus_b ();

    assign bus_a.load_start = load_start;
    assign bus_a.in_valid   = in_valid;
    assign bus_a.din        = din;
    assign bus_a.rd_en      = rd_en;
    assign bus_a.rd_addr    = rd_addr;
    assign bus_b.load_start = load_start;
    assign bus_b.in_valid   = in_valid;
    assign bus_b.din        = din;
    assign bus_b.rd_en      = rd_en;
    assign bus_b.rd_addr    = rd_addr;

    banked_bram_loader #(.LOAD_ORDER(0), .READ_LATENCY(1)) dut_a (
        .clock (clock), .reset_n (reset_n), .bus (bus_a.slave)
    );
    banked_bram_loader #(.LOAD_ORDER(1), .READ_LATENCY(2)) dut_b (
        .clock (clock), .reset_n (reset_n), .bus (bus_b.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready_a"},  64'(bus_a.in_ready),  64'd0);
        check({tag, "_in_ready_b"},  64'(bus_b.in_ready),  64'd0);
        check({tag, "_load_done_a"}, 64'(bus_a.load_done), 64'd0);
        check({tag, "_load_done_b"}, 64'(bus_b.load_done), 64'd0);
        check({tag, "_rd_valid_a"},  64'(bus_a.rd_valid),  64'd0);
        check({tag, "_rd_valid_b"},  64'(bus_b.rd_valid),  64'd0);
        check({tag, "_dout_a"},      64'(bus_a.dout),      64'd0);
        check({tag, "_dout_b"},      64'(bus_b.dout),      64'd0);
    endtask

    // One clock cycle, entered and left at a falling edge. The model reflects the matrix semantics:
    // word k of a load lands at (bank k%8, addr k/8) address-major, or (bank k/8, addr k%8) bank-major.
    task automatic tick(input bit ls, input bit iv, input logic [7:0] d, input bit re, input logic [2:0] ra);
        exp_t e;
        check("in_ready_a",  64'(bus_a.in_ready),  64'(loading));
        check("in_ready_b",  64'(bus_b.in_ready),  64'(loading));
        check("load_done_a", 64'(bus_a.load_done), 64'(loaded));
        check("load_done_b", 64'(bus_b.load_done), 64'(loaded));
        load_start = ls;
        in_valid   = iv;
        din        = d;
        rd_en      = re;
        rd_addr    = ra;
        if (re && loaded) begin
            for (int idx = 0; idx < 2; idx++) begin
                e.data = '0;
                for (int i = 0; i < 8; i++) begin
                    e.data[i*8 +: 8] = ref_mem[1'(idx)][3'(i)][ra];
                end
                e.due = cyc + lat[1'(idx)];
                q[1'(idx)].push_back(e);
            end
        end
        if (loading) begin
            if (iv) begin
                ref_mem[0][3'(words % 8)][3'(words / 8)] = d;
                ref_mem[1][3'(words / 8)][3'(words % 8)] = d;
                words++;
                if (words == NW) begin
                    loading = 1'b0;
                    loaded  = 1'b1;
                end
            end
        end else if (ls) begin
            loading = 1'b1;
            loaded  = 1'b0;
            words   = 0;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        rd_en      = 1'b0;
        loading    = 1'b0;
        loaded     = 1'b0;
        words      = 0;
        q[0].delete();
        q[1].delete();
        #1;
        check_idle_outputs("midload_reset");
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic load_stream(input logic [7:0] base, input bit gaps, input int ls_at, input int rst_at);
        int guard   = 0;
        bit ls_done = 1'b0;
        bit ls, iv;
        while (loading) begin
            if (words == rst_at) begin
                do_reset();
                return;
            end
            guard++;
            if (guard > 2000) begin
                tests++;
                fails++;
                $display("FAIL load_timeout: %0d words accepted, expected %0d", words, NW);
                return;
            end
            iv = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            ls = (words == ls_at) && !ls_done;
            if (ls) ls_done = 1'b1;
            tick(ls, iv, base + 8'(words), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end
    endtask

    task automatic read_burst(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom), 1'b1, 3'(i));
        end
    endtask

    task automatic random_ops(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)));
        end
    endtask

    task automatic mon_step(input int idx, input logic v, input logic [63:0] d);
        exp_t e;
        if (v) begin
            if (q[1'(idx)].size() == 0) begin
                check($sformatf("stray_rd_valid_%0d", idx), 64'(v), 64'd0);
            end else begin
                e = q[1'(idx)].pop_front();
                check($sformatf("rd_data_%0d", idx), d, e.data);
                check($sformatf("rd_latency_%0d", idx), 64'(cyc), 64'(e.due));
            end
        end else if (q[1'(idx)].size() != 0 && q[1'(idx)][0].due <= cyc) begin
            check($sformatf("missing_rd_valid_%0d", idx), 64'(v), 64'd1);
            void'(q[1'(idx)].pop_front());
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            mon_step(0, bus_a.rd_valid, bus_a.dout);
            mon_step(1, bus_b.rd_valid, bus_b.dout);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        load_start = 1'b0;
        in_valid   = 1'b0;
        din        = '0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        loading    = 1'b0;
        loaded     = 1'b0;
        words      = 0;

        @(negedge clock);
        check_idle_outputs("reset");
        reset_n = 1'b1;

        tick(1'b0, 1'b1, 8'h55, 1'b1, 3'd1);
        tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
        load_stream(8'd0, 1'b0, -1, -1);

        tick(1'b0, 1'b0, 8'h00, 1'b1, 3'd2);
        repeat (3) tick(1'b0, 1'b0, 8'h00, 1'b0, 3'd0);
        read_burst(8, 1'b0);
        random_ops(20);

        read_burst(4, 1'b1);
        tick(1'b1, 1'b1, 8'hAA, 1'b1, 3'd5);
        load_stream(8'd100, 1'b1, 30, -1);
        read_burst(8, 1'b1);
        random_ops(20);

        tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
        load_stream(8'd50, 1'b1, -1, 40);
        tick(1'b1, 1'b0, 8'h00, 1'b1, 3'd0);
        load_stream(8'd200, 1'b1, -1, -1);
        read_burst(8, 1'b0);
        random_ops(10);

        repeat (4) tick(1'b0, 1'b0, 8'h00, 1'b0, 3'd0);
        check("scoreboard_a_drained", 64'(q[0].size()), 64'd0);
        check("scoreboard_b_drained", 64'(q[1].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
